// File: rtl/adc_avg_pkg.sv
// adc_avg_pkg: shared constants, register map and types for the ADC averaging core
package adc_avg_pkg;
    localparam int N_CH     = 4;
    localparam int SMP_W    = 12;
    localparam int MAX_LOG2 = 8;
    localparam int ACC_W    = SMP_W + MAX_LOG2;
    localparam int CNT_W    = MAX_LOG2 + 1;
    localparam int K_W      = 4;
    localparam int DATA_W   = 16;
    localparam logic [4:0] REG_CTRL      = 5'd0;
    localparam logic [4:0] REG_STATUS    = 5'd1;
    localparam logic [4:0] REG_CLEAR     = 5'd2;
    localparam logic [4:0] REG_DATA_BASE = 5'd4;
    typedef logic [1:0] chan_idx_t;
    function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] k);
        return (k > K_W'(MAX_LOG2)) ? K_W'(MAX_LOG2) : k;
    endfunction
endpackage

// File: rtl/adc_avg_chan.sv
// adc_avg_chan: one channel's accumulator, sample counter and latched average
module adc_avg_chan
    import adc_avg_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              accept,
    input  logic              clear,
    input  logic              restart,
    input  logic [SMP_W-1:0]  smp_data,
    input  logic [K_W-1:0]    k,
    output logic [DATA_W-1:0] data,
    output logic              done
);
    logic [ACC_W-1:0]  acc_q, acc_d, sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              complete, flush;

    always_comb begin
        sum      = acc_q + ACC_W'(smp_data);
        complete = accept && ((cnt_q + CNT_W'(1)) == (CNT_W'(1) << k));
        flush    = clear || restart;
        // a clear or restart in the completing cycle discards the window
        done     = complete && !flush;
        acc_d    = (flush || complete) ? '0 : accept ? sum : acc_q;
        cnt_d    = (flush || complete) ? '0 : accept ? cnt_q + CNT_W'(1) : cnt_q;
        data_d   = done ? DATA_W'(sum >> k) : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;
endmodule

// File: rtl/adc_avg_core.sv
// adc_avg_core: MMIO slot core averaging 2^K ADC samples per channel with ready/overrun flags
module adc_avg_core
    import adc_avg_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cs,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    input  logic             smp_valid,
    input  logic [1:0]       smp_ch,
    input  logic [SMP_W-1:0] smp_data
);
    logic              en_q, en_d, wr, rd, ctrl_wr, restart;
    logic [K_W-1:0]    k_q, k_d, k_wr;
    logic [N_CH-1:0]   ready_q, ready_d, ovr_q, ovr_d, clr, rd_hit, acc_en, done;
    logic [DATA_W-1:0] data [N_CH];

    always_comb begin
        wr      = cs && write;
        rd      = cs && read;
        ctrl_wr = wr && (addr == REG_CTRL);
        k_wr    = clamp_k(wr_data[11:8]);
        en_d    = ctrl_wr ? wr_data[0] : en_q;
        k_d     = ctrl_wr ? k_wr : k_q;
        restart = !en_q || (ctrl_wr && (k_wr != k_q));
        clr     = (wr && (addr == REG_CLEAR)) ? wr_data[N_CH-1:0] : '0;
        for (int c = 0; c < N_CH; c++) begin
            rd_hit[c] = rd && (addr == REG_DATA_BASE + 5'(c));
            acc_en[c] = en_q && smp_valid && (smp_ch == chan_idx_t'(c));
        end
        // a DATA read coinciding with completion leaves ready set and suppresses overrun
        ready_d = ~clr & (done | (ready_q & ~rd_hit));
        ovr_d   = ~clr & (ovr_q | (done & ready_q & ~rd_hit));
        rd_data = (addr == REG_CTRL) ? {20'b0, k_q, 7'b0, en_q} :
                  (addr == REG_STATUS) ? {24'b0, ovr_q, ready_q} :
                  ((addr & ~5'd3) == REG_DATA_BASE) ? {16'b0, data[addr[1:0]]} : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= 1'b0;
            k_q     <= '0;
            ready_q <= '0;
            ovr_q   <= '0;
        end else begin
            en_q    <= en_d;
            k_q     <= k_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        adc_avg_chan u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .accept   (acc_en[i]),
            .clear    (clr[i]),
            .restart  (restart),
            .smp_data (smp_data),
            .k        (k_q),
            .data     (data[i]),
            .done     (done[i])
        );
    end
endmodule

// File: tb/tb_adc_avg_core.sv
// tb_adc_avg_core: directed stimulus with a read scoreboard checked by a decoupled bus monitor
module tb_adc_avg_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        smp_valid = 1'b0;
    logic [1:0]  smp_ch = '0;
    logic [11:0] smp_data = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    adc_avg_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs        (cs),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .smp_valid (smp_valid),
        .smp_ch    (smp_ch),
        .smp_data  (smp_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cs && read) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read addr=%0d got=0x%0h", addr, rd_data);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL %s got=0x%0h expected=0x%0h", n, rd_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cs = 1'b0; read = 1'b0; write = 1'b0; smp_valid = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a, input logic [31:0] e, input string n);
        cs = 1'b1; read = 1'b1; addr = a;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic set_wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    endtask

    task automatic set_smp(input logic [1:0] c, input logic [11:0] d);
        smp_valid = 1'b1; smp_ch = c; smp_data = d;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] e, input string n);
        set_rd(a, e, n);
        step();
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        set_wr(a, d);
        step();
    endtask

    task automatic smp(input logic [1:0] c, input logic [11:0] d);
        set_smp(c, d);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #23 reset_n = 1'b1;
        step();
        for (int a = 0; a < 8; a++) rd_chk(5'(a), 32'h0, $sformatf("reset_addr%0d", a));
        rd_chk(5'd31, 32'h0, "reset_unmapped");
        for (int i = 0; i < 100; i++) smp(2'(i), 12'(i * 37));
        rd_chk(5'd1, 32'h0, "disabled_status");
        rd_chk(5'd4, 32'h0, "disabled_data0");

        wr_reg(5'd0, 32'h201);
        smp(2'd1, 12'd100);
        smp(2'd1, 12'd200);
        smp(2'd1, 12'd300);
        rd_chk(5'd1, 32'h0, "k2_status_partial");
        smp(2'd1, 12'd401);
        rd_chk(5'd1, 32'h2, "k2_status_ready1");
        rd_chk(5'd5, 32'd250, "k2_data1");
        rd_chk(5'd1, 32'h0, "k2_status_after_read");

        wr_reg(5'd0, 32'h301);
        for (int i = 0; i < 16; i++) smp(2'd0, 12'hFFF);
        rd_chk(5'd0, 32'h301, "ctrl_k3");
        rd_chk(5'd1, 32'h11, "k3_status_ovr0");
        rd_chk(5'd4, 32'hFFF, "k3_data0");
        wr_reg(5'd2, 32'h1);
        rd_chk(5'd1, 32'h0, "k3_status_cleared");
        rd_chk(5'd4, 32'hFFF, "k3_data0_kept");

        wr_reg(5'd0, 32'h001);
        smp(2'd3, 12'h055);
        set_smp(2'd3, 12'h123);
        set_rd(5'd7, 32'h055, "k0_read_coincident_old");
        step();
        rd_chk(5'd1, 32'h8, "k0_status_ready3_no_ovr");
        rd_chk(5'd7, 32'h123, "k0_data3_new");
        rd_chk(5'd1, 32'h0, "k0_status_after_read");

        wr_reg(5'd0, 32'h201);
        for (int i = 0; i < 3; i++) smp(2'd2, 12'd7);
        set_wr(5'd0, 32'h101);
        set_smp(2'd2, 12'd50);
        step();
        smp(2'd2, 12'd10);
        smp(2'd2, 12'd10);
        rd_chk(5'd1, 32'h4, "kchg_status_ready2");
        rd_chk(5'd2, 32'h0, "clear_reads_zero");
        rd_chk(5'd6, 32'd10, "kchg_data2");

        smp(2'd0, 12'd99);
        #2 reset_n = 1'b0;
        #1;
        rd_chk(5'd0, 32'h0, "rst_ctrl");
        rd_chk(5'd1, 32'h0, "rst_status");
        rd_chk(5'd4, 32'h0, "rst_data0");
        rd_chk(5'd5, 32'h0, "rst_data1");
        reset_n = 1'b1;
        step();

        wr_reg(5'd0, 32'h101);
        smp(2'd0, 12'd20);
        smp(2'd0, 12'd40);
        rd_chk(5'd4, 32'd30, "k1_data0");
        smp(2'd0, 12'd100);
        set_smp(2'd0, 12'd200);
        set_wr(5'd2, 32'h1);
        step();
        rd_chk(5'd1, 32'h0, "clr_vs_complete_status");
        rd_chk(5'd4, 32'd30, "clr_vs_complete_data0");
        set_smp(2'd0, 12'd500);
        set_wr(5'd2, 32'h1);
        step();
        smp(2'd0, 12'd2);
        smp(2'd0, 12'd4);
        rd_chk(5'd1, 32'h1, "clr_drop_status");
        rd_chk(5'd4, 32'd3, "clr_drop_data0");
        wr_reg(5'd0, 32'hF01);
        rd_chk(5'd0, 32'h801, "ctrl_k_clamped");
        wr_reg(5'd1, 32'hFF);
        rd_chk(5'd1, 32'h0, "status_ro");
        wr_reg(5'd3, 32'hFFFF);
        rd_chk(5'd3, 32'h0, "unmapped_wr_ignored");

        step();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
